// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the cpu, ext and memory-side signals of the data
// memory arbiter. The arbiter connects through the slave modport. The
// environment (core, external master, memory) connects through the master
// modport.
//
// Handshake: a request (cpu_req / ext_req) is a level held by its master.
// A beat is accepted in any cycle where the request is high and that master
// is granted: for cpu, cpu_stall=0; for ext, ext_gnt=1. The master keeps
// address, data and write enable stable until the beat is accepted. Read data
// is returned exactly one cycle after acceptance and is qualified by the
// matching rvalid.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              ext_req;
    logic              ext_we;
    logic              ext_lock;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between the core
// (cpu port) and an external master (ext port). At most one access is issued
// per cycle. The cpu normally wins. A starvation counter forces ext through
// after STARVE_MAX denied cycles. Locked ext bursts are broken by a one-cycle
// cpu yield after LOCK_MAX beats.
// Optional feature: define DMEM_ARB_STATS_EN to add the saturating
// cpu_stall_cnt / ext_wait_cnt statistics outputs.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 16
) (
    input  logic        clk,
    input  logic        reset,
    dmem_arbiter_if.slave bus,
    output logic [1:0]  state_dbg
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0] cpu_stall_cnt,
    output logic [15:0] ext_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_LOCKED = 2'd1,
        ST_YIELD  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic [7:0] lock_cnt;
    logic [7:0] lock_nxt;
    logic       cpu_gnt;
    logic       ext_gnt_w;

    // Grant decision and next-state logic; grants are forced off while reset
    // is held low.
    always_comb begin
        cpu_gnt   = 1'b0;
        ext_gnt_w = 1'b0;
        state_nxt = state;
        lock_nxt  = lock_cnt;
        if (reset) begin
            case (state)
                ST_NORMAL: begin
                    if (bus.ext_req && (!bus.cpu_req || starve_cnt == STARVE_LIM)) begin
                        ext_gnt_w = 1'b1;
                    end else if (bus.cpu_req) begin
                        cpu_gnt = 1'b1;
                    end
                    if (ext_gnt_w && bus.ext_lock) begin
                        state_nxt = ST_LOCKED;
                        lock_nxt  = 8'd1;
                    end
                end
                ST_LOCKED: begin
                    // ext owns the memory outright; cpu waits even if ext is idle.
                    ext_gnt_w = bus.ext_req;
                    if (!bus.ext_req || !bus.ext_lock) begin
                        state_nxt = ST_NORMAL;
                        lock_nxt  = 8'd0;
                    end else begin
                        lock_nxt = (lock_cnt >= LOCK_LIM) ? LOCK_LIM : lock_cnt + 8'd1;
                        if (lock_nxt == LOCK_LIM && bus.cpu_req) begin
                            state_nxt = ST_YIELD;
                        end
                    end
                end
                ST_YIELD: begin
                    cpu_gnt  = bus.cpu_req;
                    lock_nxt = 8'd0;
                    if (bus.ext_req && bus.ext_lock) begin
                        state_nxt = ST_LOCKED;
                    end else begin
                        state_nxt = ST_NORMAL;
                    end
                end
                default: begin
                    state_nxt = ST_NORMAL;
                    lock_nxt  = 8'd0;
                end
            endcase
        end
    end

    // Memory bus mux: the granted master drives the memory, otherwise all zero.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_gnt) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (ext_gnt_w) begin
            bus.mem_we    = bus.ext_we;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
        end
    end

    assign bus.mem_en    = cpu_gnt | ext_gnt_w;
    assign bus.ext_gnt   = ext_gnt_w;
    assign bus.cpu_stall = reset & bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.ext_rdata = bus.mem_rdata;
    assign state_dbg     = state;

    // FSM state and lock beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_NORMAL;
            lock_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    // Starvation counter: counts consecutive denied ext cycles, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (!bus.ext_req || ext_gnt_w) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read-owner tracking: the memory returns data one cycle after a read issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cpu_rvalid <= 1'b0;
            bus.ext_rvalid <= 1'b0;
        end else begin
            bus.cpu_rvalid <= cpu_gnt & ~bus.cpu_we;
            bus.ext_rvalid <= ext_gnt_w & ~bus.ext_we;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating stall and wait statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_stall_cnt <= 16'd0;
            ext_wait_cnt  <= 16'd0;
        end else begin
            if (bus.cpu_stall && cpu_stall_cnt != 16'hFFFF) begin
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            end
            if (bus.ext_req && !ext_gnt_w && ext_wait_cnt != 16'hFFFF) begin
                ext_wait_cnt <= ext_wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. It has a table of
// single-access vectors plus hand-written sequences for starvation, lock
// yield, lock drop and reset mid-lock.
module tb_dmem_arbiter;
    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cpu_stall_cnt;
    logic [15:0] ext_wait_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4), .LOCK_MAX(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef DMEM_ARB_STATS_EN
        ,
        .cpu_stall_cnt (cpu_stall_cnt),
        .ext_wait_cnt  (ext_wait_cnt)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: preload image plus write overlay, 1-cycle read latency
    logic [7:0] preload [256];
    logic [7:0] wmem    [256];
    bit         wvld    [256];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                wmem[bus.mem_addr] <= bus.mem_wdata;
                wvld[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= wvld[bus.mem_addr] ? wmem[bus.mem_addr] : preload[bus.mem_addr];
            end
        end
    end

    function automatic logic [7:0] mem_peek(input logic [7:0] a);
        return wvld[a] ? wmem[a] : preload[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
    endtask

    task automatic drive_ext(input logic req, input logic we, input logic lock, input logic [7:0] addr, input logic [7:0] wd);
        bus.ext_req   = req;
        bus.ext_we    = we;
        bus.ext_lock  = lock;
        bus.ext_addr  = addr;
        bus.ext_wdata = wd;
    endtask

    task automatic idle();
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        drive_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       c_req, c_we;
        logic [7:0] c_addr, c_wd;
        logic       e_req, e_we;
        logic [7:0] e_addr, e_wd;
        logic       x_en, x_we;
        logic [7:0] x_addr, x_wd;
        logic       x_stall, x_gnt, x_crv, x_erv;
        logic [7:0] x_rd;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        logic prev_cpu;
        logic exp_ext;
        logic [7:0] b;

        for (int i = 0; i < 256; i++) preload[i] = 8'h00;
        preload[8'h10] = 8'hA5;
        preload[8'h20] = 8'h5A;
        preload[8'h12] = 8'h77;
        preload[8'h22] = 8'h66;
        preload[8'h23] = 8'hEE;

        //            c_req c_we  c_addr c_wd   e_req e_we  e_addr e_wd   en    we    addr   wd     stall gnt   crv   erv   rdata
        vec[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vec[1] = '{1'b1, 1'b1, 8'h11, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h11, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A};
        vec[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h21, 8'hC3, 1'b1, 1'b1, 8'h21, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[4] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77};
        vec[5] = '{1'b1, 1'b1, 8'h13, 8'h11, 1'b1, 1'b1, 8'h23, 8'h22, 1'b1, 1'b1, 8'h13, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[6] = '{1'b0, 1'b1, 8'h55, 8'h99, 1'b0, 1'b1, 8'h66, 8'h88, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[7] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
        vec[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3};
        vec[9] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h23, 8'h00, 1'b1, 1'b0, 8'h23, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEE};

        // reset state with both requests asserted
        reset = 1'b0;
        drive_cpu(1'b1, 1'b1, 8'h10, 8'h00);
        drive_ext(1'b1, 1'b1, 1'b1, 8'h20, 8'h00);
        #1;
        chk("rst mem_en", bus.mem_en, 1'b0);
        chk("rst mem_we", bus.mem_we, 1'b0);
        chk("rst ext_gnt", bus.ext_gnt, 1'b0);
        chk("rst cpu_stall", bus.cpu_stall, 1'b0);
        chk("rst cpu_rvalid", bus.cpu_rvalid, 1'b0);
        chk("rst ext_rvalid", bus.ext_rvalid, 1'b0);
        chk("rst state", state_dbg, 2'd0);
        do_reset();

        // table vectors, each followed by an idle cycle for read return
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_cpu(vec[i].c_req, vec[i].c_we, vec[i].c_addr, vec[i].c_wd);
            drive_ext(vec[i].e_req, vec[i].e_we, 1'b0, vec[i].e_addr, vec[i].e_wd);
            #1;
            chk($sformatf("v%0d mem_en", i), bus.mem_en, vec[i].x_en);
            chk($sformatf("v%0d mem_we", i), bus.mem_we, vec[i].x_we);
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vec[i].x_addr);
            chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vec[i].x_wd);
            chk($sformatf("v%0d cpu_stall", i), bus.cpu_stall, vec[i].x_stall);
            chk($sformatf("v%0d ext_gnt", i), bus.ext_gnt, vec[i].x_gnt);
            @(negedge clk);
            idle();
            #1;
            chk($sformatf("v%0d cpu_rvalid", i), bus.cpu_rvalid, vec[i].x_crv);
            chk($sformatf("v%0d ext_rvalid", i), bus.ext_rvalid, vec[i].x_erv);
            if (vec[i].x_crv) chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, vec[i].x_rd);
            if (vec[i].x_erv) chk($sformatf("v%0d ext_rdata", i), bus.ext_rdata, vec[i].x_rd);
        end

        // starvation: both held, ext forced through on cycles 5 and 10
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
            drive_ext(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
            #1;
            exp_ext = (k == 5 || k == 10);
            chk($sformatf("starve c%0d ext_gnt", k), bus.ext_gnt, exp_ext);
            chk($sformatf("starve c%0d cpu_stall", k), bus.cpu_stall, exp_ext);
            chk($sformatf("starve c%0d mem_addr", k), bus.mem_addr, exp_ext ? 8'h20 : 8'h10);
        end
        @(negedge clk);
        idle();
        #1;
`ifdef DMEM_ARB_STATS_EN
        chk("stats ext_wait_cnt", ext_wait_cnt, 16'd8);
        chk("stats cpu_stall_cnt", cpu_stall_cnt, 16'd2);
`endif

        // locked 20-beat ext write burst against a steady cpu read
        do_reset();
        b = 8'd1;
        prev_cpu = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
            drive_ext(b <= 8'd20, 1'b1, b < 8'd20, 8'h40 + b, 8'h80 + b);
            #1;
            exp_ext = (c >= 5 && c <= 20) || (c >= 22 && c <= 25);
            chk($sformatf("lock c%0d ext_gnt", c), bus.ext_gnt, exp_ext);
            chk($sformatf("lock c%0d cpu_stall", c), bus.cpu_stall, exp_ext);
            chk($sformatf("lock c%0d mem_addr", c), bus.mem_addr, exp_ext ? 8'h40 + b : 8'h10);
            chk($sformatf("lock c%0d cpu_rvalid", c), bus.cpu_rvalid, prev_cpu);
            if (c == 21) chk("lock yield state", state_dbg, 2'd2);
            prev_cpu = !exp_ext;
            if (bus.ext_gnt) b = b + 8'd1;
        end
        @(negedge clk);
        idle();
        #1;
        for (int j = 1; j <= 20; j++) begin
            chk($sformatf("lock beat%0d data", j), mem_peek(8'(8'h40 + j)), 8'(8'h80 + j));
        end

        // lock dropped on beat 3: cpu granted the following cycle
        do_reset();
        @(negedge clk);
        drive_ext(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
        #1;
        chk("drop c1 ext_gnt", bus.ext_gnt, 1'b1);
        @(negedge clk);
        drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        drive_ext(1'b1, 1'b0, 1'b1, 8'h21, 8'h00);
        #1;
        chk("drop c2 state", state_dbg, 2'd1);
        chk("drop c2 ext_gnt", bus.ext_gnt, 1'b1);
        chk("drop c2 cpu_stall", bus.cpu_stall, 1'b1);
        chk("drop c2 ext_rvalid", bus.ext_rvalid, 1'b1);
        chk("drop c2 ext_rdata", bus.ext_rdata, 8'h5A);
        @(negedge clk);
        drive_ext(1'b1, 1'b0, 1'b0, 8'h22, 8'h00);
        #1;
        chk("drop c3 ext_gnt", bus.ext_gnt, 1'b1);
        chk("drop c3 cpu_stall", bus.cpu_stall, 1'b1);
        chk("drop c3 ext_rdata", bus.ext_rdata, 8'hC3);
        @(negedge clk);
        drive_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("drop c4 state", state_dbg, 2'd0);
        chk("drop c4 cpu_stall", bus.cpu_stall, 1'b0);
        chk("drop c4 mem_addr", bus.mem_addr, 8'h10);
        chk("drop c4 ext_rdata", bus.ext_rdata, 8'h66);
        @(negedge clk);
        idle();
        #1;
        chk("drop c5 cpu_rvalid", bus.cpu_rvalid, 1'b1);
        chk("drop c5 cpu_rdata", bus.cpu_rdata, 8'hA5);

        // reset asserted while a locked ext read is being issued
        do_reset();
        @(negedge clk);
        drive_ext(1'b1, 1'b0, 1'b1, 8'h30, 8'h00);
        #1;
        chk("rlock c1 ext_gnt", bus.ext_gnt, 1'b1);
        @(negedge clk);
        drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        drive_ext(1'b1, 1'b0, 1'b1, 8'h31, 8'h00);
        #1;
        chk("rlock c2 ext_gnt", bus.ext_gnt, 1'b1);
        chk("rlock c2 cpu_stall", bus.cpu_stall, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("rlock asserted mem_en", bus.mem_en, 1'b0);
        chk("rlock asserted ext_gnt", bus.ext_gnt, 1'b0);
        chk("rlock asserted cpu_stall", bus.cpu_stall, 1'b0);
        @(negedge clk);
        #1;
        chk("rlock held ext_rvalid", bus.ext_rvalid, 1'b0);
        chk("rlock held state", state_dbg, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        drive_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rlock post mem_en", bus.mem_en, 1'b1);
        chk("rlock post cpu_stall", bus.cpu_stall, 1'b0);
        chk("rlock post mem_addr", bus.mem_addr, 8'h10);
        chk("rlock post ext_rvalid", bus.ext_rvalid, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("rlock post2 ext_rvalid", bus.ext_rvalid, 1'b0);
        chk("rlock post2 cpu_rvalid", bus.cpu_rvalid, 1'b1);
        chk("rlock post2 cpu_rdata", bus.cpu_rdata, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
